// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result
// flags and the index-counter width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  // A single-digit operand still needs a 1-bit index register.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice; the top walks the operands
// MSB-first through this single instance.
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dgt,
  output logic             dlt
);

  assign dgt = (x > y);
  assign dlt = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans latched operands MSB-first, DIGIT
// bits per clock, with optional early exit and two's complement mode.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N_DIG = WIDTH / DIGIT;
  localparam int IW    = cnt_w(N_DIG);
  localparam logic [IW-1:0]    IDX_MAX  = IW'(N_DIG - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             dgt_q, dlt_q;
  result_t          res_q;

  logic [DIGIT-1:0] x_dig, y_dig;
  logic             dgt, dlt;
  logic             undecided, fin_gt, fin_lt, scan_end;

  assign x_dig = a_q[int'(idx_q)*DIGIT +: DIGIT];
  assign y_dig = b_q[int'(idx_q)*DIGIT +: DIGIT];

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .x   (x_dig),
    .y   (y_dig),
    .dgt (dgt),
    .dlt (dlt)
  );

  // The first differing digit decides; later digits cannot override it.
  assign undecided = ~dgt_q & ~dlt_q;
  assign fin_gt    = dgt_q | (undecided & dgt);
  assign fin_lt    = dlt_q | (undecided & dlt);
  assign scan_end  = (idx_q == '0) || ((EARLY_EXIT != 0) && (dgt || dlt));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    eq   = res_q.eq;
    gt   = res_q.gt;
    lt   = res_q.lt;
  end

  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned digit scan orders signed operands correctly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      dgt_q <= 1'b0;
      dlt_q <= 1'b0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a ^ (signed_mode ? SIGN_BIT : '0);
            b_q   <= b ^ (signed_mode ? SIGN_BIT : '0);
            idx_q <= IDX_MAX;
            dgt_q <= 1'b0;
            dlt_q <= 1'b0;
            res_q <= '0;
          end
        end
        SCAN: begin
          dgt_q <= fin_gt;
          dlt_q <= fin_lt;
          if (scan_end) res_q <= {~(fin_gt | fin_lt), fin_gt, fin_lt};
          else          idx_q <= idx_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
